// File: rtl/hazard_stall_controller_if.sv
// Bundle of ID/EX/MEM hazard inputs and PC/IF-ID control outputs for the
// pipeline hazard stall controller.
interface hazard_stall_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] ID_Rs;
    logic [REG_ADDR_W-1:0] ID_Rt;
    logic                  ID_UsesRs;
    logic                  ID_UsesRt;
    logic                  ID_IsBranch;
    logic                  EX_MemRead;
    logic                  EX_RegWrite;
    logic [REG_ADDR_W-1:0] EX_WriteReg;
    logic                  MEM_MemRead;
    logic [REG_ADDR_W-1:0] MEM_WriteReg;
    logic                  BranchTaken;
    logic                  CountClear;
    logic                  PC_WriteEnable;
    logic                  IFID_WriteEnable;
    logic                  IDEX_Bubble;
    logic                  IFID_Flush;
    logic                  Stalling;
    logic [CNT_W-1:0]      StallCount;

    // Pipeline side: drives stage fields, consumes the enables.
    modport master (
        output ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch,
               EX_MemRead, EX_RegWrite, EX_WriteReg,
               MEM_MemRead, MEM_WriteReg, BranchTaken, CountClear,
        input  PC_WriteEnable, IFID_WriteEnable, IDEX_Bubble,
               IFID_Flush, Stalling, StallCount
    );

    // Controller side.
    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRs, ID_UsesRt, ID_IsBranch,
               EX_MemRead, EX_RegWrite, EX_WriteReg,
               MEM_MemRead, MEM_WriteReg, BranchTaken, CountClear,
        output PC_WriteEnable, IFID_WriteEnable, IDEX_Bubble,
               IFID_Flush, Stalling, StallCount
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard controller: load-use with configurable latency, branch-in-ID
// operand hazards, taken-branch IF/ID flush, multi-cycle stall FSM and a
// saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_STALL = 1,
    parameter int BRANCH_IN_ID = 1,
    parameter int CNT_W        = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    hazard_stall_controller_if.slave bus
);

    typedef enum logic {IDLE, STALL} state_t;

    localparam logic       BR_EN = (BRANCH_IN_ID != 0);
    localparam logic [3:0] LS_N  = 4'(LOAD_STALL);
    localparam logic [3:0] LSB_N = 4'(LOAD_STALL + 1);
    localparam logic [3:0] BS_N  = 4'(BRANCH_STALL);

    state_t           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       m_ex, m_mem;
    logic       lu, bex, bld;
    logic [3:0] need_n;
    logic       stall_now;
    logic       pc_we, ifid_we, bubble, flush, stalling;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign m_ex  = (bus.EX_WriteReg != '0) &&
                   ((bus.ID_UsesRs && (bus.ID_Rs == bus.EX_WriteReg)) ||
                    (bus.ID_UsesRt && (bus.ID_Rt == bus.EX_WriteReg)));
    assign m_mem = (bus.MEM_WriteReg != '0) &&
                   ((bus.ID_UsesRs && (bus.ID_Rs == bus.MEM_WriteReg)) ||
                    (bus.ID_UsesRt && (bus.ID_Rt == bus.MEM_WriteReg)));

    assign lu  = bus.EX_MemRead && bus.EX_RegWrite && m_ex;
    assign bex = BR_EN && bus.ID_IsBranch && bus.EX_RegWrite && !bus.EX_MemRead && m_ex;
    assign bld = BR_EN && bus.ID_IsBranch && bus.MEM_MemRead && m_mem;

    // Required stall length: maximum over all active hazard terms.
    always_comb begin
        need_n = '0;
        if (bld) need_n = 4'd1;
        if (bex && (BS_N > need_n)) need_n = BS_N;
        if (lu && (LS_N > need_n)) need_n = LS_N;
        if (lu && bus.ID_IsBranch && BR_EN) need_n = LSB_N;
    end

    // Stall FSM next state and remaining-cycle counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (need_n != '0) begin
                    stall_now = 1'b1;
                    cnt_d     = 3'(need_n - 4'd1);
                    if (need_n > 4'd1) state_d = STALL;
                end
            end
            STALL: begin
                stall_now = 1'b1;
                cnt_d     = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; reset overrides everything so the pipeline free-runs.
    always_comb begin
        pc_we    = 1'b1;
        ifid_we  = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;
        stalling = 1'b0;
        if (Reset) begin
            if (stall_now) begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                bubble  = 1'b1;
            end
            stalling = (state_q == STALL);
            flush    = BR_EN && bus.BranchTaken && !stall_now;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (bus.CountClear) begin
            count_d = '0;
        end else if (stall_now && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // State, stall counter and performance counter registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign bus.PC_WriteEnable   = pc_we;
    assign bus.IFID_WriteEnable = ifid_we;
    assign bus.IDEX_Bubble      = bubble;
    assign bus.IFID_Flush       = flush;
    assign bus.Stalling         = stalling;
    assign bus.StallCount       = count_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: three instances share one
// stimulus stream (A: defaults, B: LOAD_STALL=3, C: CNT_W=4).
module tb_hazard_stall_controller;

    localparam logic [4:0] RUN = 5'b11000; // {pcwe, ifidwe, bubble, flush, stalling}
    localparam logic [4:0] STL = 5'b00100;
    localparam logic [4:0] STS = 5'b00101;
    localparam logic [4:0] FLS = 5'b11010;
    localparam int DA = 0;
    localparam int DB = 1;
    localparam int DC = 2;

    typedef struct {
        string       tag;
        int          dut;
        logic [4:0]  ctl;
        int unsigned cnt;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_wr, mem_wr;
    logic       uses_rs, uses_rt, is_br, ex_mr, ex_rw, mem_mr, br_tk, cclr;

    hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) if_a ();
    hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(16)) if_b ();
    hazard_stall_controller_if #(.REG_ADDR_W(5), .CNT_W(4))  if_c ();

    assign if_a.ID_Rs = id_rs, if_a.ID_Rt = id_rt, if_a.ID_UsesRs = uses_rs, if_a.ID_UsesRt = uses_rt,
           if_a.ID_IsBranch = is_br, if_a.EX_MemRead = ex_mr, if_a.EX_RegWrite = ex_rw,
           if_a.EX_WriteReg = ex_wr, if_a.MEM_MemRead = mem_mr, if_a.MEM_WriteReg = mem_wr,
           if_a.BranchTaken = br_tk, if_a.CountClear = cclr;
    assign if_b.ID_Rs = id_rs, if_b.ID_Rt = id_rt, if_b.ID_UsesRs = uses_rs, if_b.ID_UsesRt = uses_rt,
           if_b.ID_IsBranch = is_br, if_b.EX_MemRead = ex_mr, if_b.EX_RegWrite = ex_rw,
           if_b.EX_WriteReg = ex_wr, if_b.MEM_MemRead = mem_mr, if_b.MEM_WriteReg = mem_wr,
           if_b.BranchTaken = br_tk, if_b.CountClear = cclr;
    assign if_c.ID_Rs = id_rs, if_c.ID_Rt = id_rt, if_c.ID_UsesRs = uses_rs, if_c.ID_UsesRt = uses_rt,
           if_c.ID_IsBranch = is_br, if_c.EX_MemRead = ex_mr, if_c.EX_RegWrite = ex_rw,
           if_c.EX_WriteReg = ex_wr, if_c.MEM_MemRead = mem_mr, if_c.MEM_WriteReg = mem_wr,
           if_c.BranchTaken = br_tk, if_c.CountClear = cclr;

    hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_STALL(1), .BRANCH_STALL(1), .BRANCH_IN_ID(1), .CNT_W(16))
        u_a (.Clock(clk), .Reset(rst_n), .bus(if_a));
    hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_STALL(3), .BRANCH_STALL(1), .BRANCH_IN_ID(1), .CNT_W(16))
        u_b (.Clock(clk), .Reset(rst_n), .bus(if_b));
    hazard_stall_controller #(.REG_ADDR_W(5), .LOAD_STALL(1), .BRANCH_STALL(1), .BRANCH_IN_ID(1), .CNT_W(4))
        u_c (.Clock(clk), .Reset(rst_n), .bus(if_c));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic get_obs(input int d, output logic [4:0] ctl, output int unsigned cnt);
        case (d)
            DA: begin
                ctl = {if_a.PC_WriteEnable, if_a.IFID_WriteEnable, if_a.IDEX_Bubble, if_a.IFID_Flush, if_a.Stalling};
                cnt = 32'(if_a.StallCount);
            end
            DB: begin
                ctl = {if_b.PC_WriteEnable, if_b.IFID_WriteEnable, if_b.IDEX_Bubble, if_b.IFID_Flush, if_b.Stalling};
                cnt = 32'(if_b.StallCount);
            end
            default: begin
                ctl = {if_c.PC_WriteEnable, if_c.IFID_WriteEnable, if_c.IDEX_Bubble, if_c.IFID_Flush, if_c.Stalling};
                cnt = 32'(if_c.StallCount);
            end
        endcase
    endtask

    task automatic expect_out(input string tag, input int d, input logic [4:0] ctl, input int unsigned cnt);
        exp_t e;
        e.tag = tag; e.dut = d; e.ctl = ctl; e.cnt = cnt;
        sb.push_back(e);
    endtask

    task automatic expect3(input string tag, input logic [4:0] ctl, input int unsigned cnt);
        expect_out({tag, "_a"}, DA, ctl, cnt);
        expect_out({tag, "_b"}, DB, ctl, cnt);
        expect_out({tag, "_c"}, DC, ctl, cnt);
    endtask

    task automatic drain();
        exp_t        e;
        logic [4:0]  ctl;
        int unsigned cnt;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            get_obs(e.dut, ctl, cnt);
            check_val({e.tag, "_ctl"}, 32'(ctl), 32'(e.ctl));
            check_val({e.tag, "_cnt"}, cnt, e.cnt);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are compared 2 units later.
    task automatic next_cycle();
        #2 drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_rs = '0; id_rt = '0; uses_rs = 1'b0; uses_rt = 1'b0; is_br = 1'b0;
        ex_mr = 1'b0; ex_rw = 1'b0; ex_wr = '0; mem_mr = 1'b0; mem_wr = '0;
        br_tk = 1'b0; cclr = 1'b0;
    endtask

    // EX: lw $exwr ; ID: add $9,$8,$3
    task automatic set_lu(input logic [4:0] exwr);
        set_idle();
        ex_mr = 1'b1; ex_rw = 1'b1; ex_wr = exwr;
        id_rs = 5'd8; uses_rs = 1'b1; id_rt = 5'd3; uses_rt = 1'b1;
    endtask

    // ID: beq $5,$0 with EX writing $5 (ALU op when load=0, lw when load=1)
    task automatic set_br_ex(input logic load);
        set_idle();
        ex_rw = 1'b1; ex_mr = load; ex_wr = 5'd5;
        id_rs = 5'd5; uses_rs = 1'b1; id_rt = 5'd0; uses_rt = 1'b1; is_br = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) next_cycle();
    endtask

    task automatic clear_cycle();
        set_idle();
        cclr = 1'b1;
        next_cycle();
        cclr = 1'b0;
    endtask

    initial begin
        // Reset held with a live load-use hazard on the inputs.
        rst_n = 1'b0;
        set_lu(5'd8);
        #3;
        expect3("rst0", RUN, 0);
        drain();
        @(posedge clk);
        #1;
        expect3("rst1", RUN, 0);
        #2 drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Load-use; B then sees EX_WriteReg change mid-stall.
        clear_cycle();
        set_lu(5'd8);  expect3("lu1", STL, 0); next_cycle();
        set_lu(5'd12); expect_out("lu2_a", DA, RUN, 1); expect_out("lu2_b", DB, STS, 1);
                       expect_out("lu2_c", DC, RUN, 1); next_cycle();
        set_lu(5'd12); expect_out("lu3_b", DB, STS, 2); next_cycle();
        set_idle();    expect_out("lu4_a", DA, RUN, 1); expect_out("lu4_b", DB, RUN, 3); next_cycle();

        // Branch depending on an ALU result in EX.
        clear_cycle();
        set_br_ex(1'b0); expect3("bex1", STL, 0); next_cycle();
        set_idle();      expect3("bex2", RUN, 1); next_cycle();

        // Branch depending on a load in EX: LOAD_STALL+1 cycles.
        clear_cycle();
        set_br_ex(1'b1); expect_out("blw1_a", DA, STL, 0); expect_out("blw1_b", DB, STL, 0); next_cycle();
        set_idle();      expect_out("blw2_a", DA, STS, 1); expect_out("blw2_b", DB, STS, 1); next_cycle();
                         expect_out("blw3_a", DA, RUN, 2); expect_out("blw3_b", DB, STS, 2); next_cycle();
                         expect_out("blw4_b", DB, STS, 3); next_cycle();
                         expect_out("blw5_b", DB, RUN, 4); next_cycle();

        // Branch depending on a load in MEM: one cycle.
        clear_cycle();
        set_idle(); mem_mr = 1'b1; mem_wr = 5'd7; id_rs = 5'd7; uses_rs = 1'b1; is_br = 1'b1;
        expect3("bld1", STL, 0); next_cycle();
        set_idle(); expect3("bld2", RUN, 1); next_cycle();

        // Register 0 never matches.
        set_idle(); ex_mr = 1'b1; ex_rw = 1'b1; uses_rs = 1'b1; is_br = 1'b1; mem_mr = 1'b1;
        expect3("r0", RUN, 1); next_cycle();

        // Taken-branch flush, and its suppression while stalling.
        set_idle(); br_tk = 1'b1; expect3("fl1", FLS, 1); next_cycle();
        set_idle();               expect3("fl2", RUN, 1); next_cycle();
        set_lu(5'd8); br_tk = 1'b1; expect3("fl3", STL, 1); next_cycle();
        set_idle(); br_tk = 1'b1;
        expect_out("fl4_a", DA, FLS, 2); expect_out("fl4_b", DB, STS, 2); next_cycle();
        idle_cycles(4);

        // Asynchronous reset during the 2nd cycle of B's 3-cycle stall.
        clear_cycle();
        set_lu(5'd8);  expect_out("rs1_b", DB, STL, 0); next_cycle();
        set_lu(5'd12); expect_out("rs2_b", DB, STS, 1);
        #2 drain();
        rst_n = 1'b0;
        #1 expect3("rs3", RUN, 0); drain();
        set_lu(5'd8);
        #1 expect3("rs4", RUN, 0); drain();
        @(posedge clk);
        #1 expect3("rs5", RUN, 0);
        #2 drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_idle(); expect3("rs6", RUN, 0); next_cycle();
                    expect3("rs7", RUN, 0); next_cycle();

        // Saturation of the 4-bit counter over 20 stall cycles.
        for (int i = 0; i < 20; i++) begin
            set_lu(5'd8);
            expect_out($sformatf("sat%0d_c", i), DC, STL, (i > 15) ? 15 : i);
            expect_out($sformatf("sat%0d_a", i), DA, STL, i);
            next_cycle();
        end
        set_idle(); expect_out("sat_end_c", DC, RUN, 15); expect_out("sat_end_a", DA, RUN, 20); next_cycle();

        // Clear takes priority over a coincident stall.
        set_lu(5'd8); cclr = 1'b1;
        expect_out("clr1_c", DC, STL, 15); expect_out("clr1_a", DA, STL, 20); next_cycle();
        set_idle(); expect_out("clr2_c", DC, RUN, 0); expect_out("clr2_a", DA, RUN, 0); next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It generalises single-cycle load-use detection to a configurable load latency, and adds branch-in-ID operand hazards and taken-branch IF/ID flush. A small stall FSM with a down-counter holds PC and IF/ID for multi-cycle stalls. A saturating counter records stall cycles for performance measurement. It sits between the ID stage, the ID/EX and EX/MEM pipeline registers, and the PC/IF-ID write-enable logic.

Parameters:
REG_ADDR_W, 5, register-address width
LOAD_STALL, 1, stall cycles for load-use (legal 1..7)
BRANCH_STALL, 1, stall cycles for branch in ID depending on an EX-stage ALU result (legal 0..7)
BRANCH_IN_ID, 1, 1 = branch hazard terms and flush enabled; 0 = branch inputs ignored
CNT_W, 16, stall-counter width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
ID_Rs  in  REG_ADDR_W  rs field of the instruction in ID
ID_Rt  in  REG_ADDR_W  rt field of the instruction in ID
ID_UsesRs  in  1  ID instruction reads rs
ID_UsesRt  in  1  ID instruction reads rt
ID_IsBranch  in  1  ID instruction is a branch resolved in ID
EX_MemRead  in  1  ID/EX instruction is a load
EX_RegWrite  in  1  ID/EX instruction writes a register
EX_WriteReg  in  REG_ADDR_W  ID/EX destination register
MEM_MemRead  in  1  EX/MEM instruction is a load
MEM_WriteReg  in  REG_ADDR_W  EX/MEM destination register
BranchTaken  in  1  branch resolved taken in ID this cycle
CountClear  in  1  synchronous clear of StallCount
PC_WriteEnable  out  1  1 = PC may update
IFID_WriteEnable  out  1  1 = IF/ID may update
IDEX_Bubble  out  1  1 = load NOP control into ID/EX
IFID_Flush  out  1  1 = zero IF/ID on next edge
Stalling  out  1  FSM is in STALL
StallCount  out  CNT_W  saturating count of stall cycles

Behaviour:
- Match terms:
  - mEX = EX_WriteReg != 0 && ((ID_UsesRs && ID_Rs == EX_WriteReg) || (ID_UsesRt && ID_Rt == EX_WriteReg)).
  - mMEM is the same test against MEM_WriteReg.
  - Register 0 never matches.
- Hazard terms:
  - lu = EX_MemRead && EX_RegWrite && mEX.
  - bex = BRANCH_IN_ID && ID_IsBranch && EX_RegWrite && !EX_MemRead && mEX.
  - bld = BRANCH_IN_ID && ID_IsBranch && MEM_MemRead && mMEM.
- Required stall N is the maximum of:
  - lu && ID_IsBranch && BRANCH_IN_ID → LOAD_STALL+1
  - lu → LOAD_STALL
  - bex → BRANCH_STALL
  - bld → 1
  - none → 0
- FSM states: IDLE, STALL. 3-bit down-counter cnt.
- IDLE, N>0:
  - Same cycle, combinationally: PC_WriteEnable=0, IFID_WriteEnable=0, IDEX_Bubble=1.
  - On the edge: cnt<=N-1; go to STALL if N-1>0, else stay in IDLE.
- IDLE, N=0: enables=1, bubble=0.
- STALL:
  - Enables=0, bubble=1, Stalling=1.
  - Hazard inputs are ignored.
  - cnt decrements each edge; when cnt==1 at the edge, go to IDLE.
  - Total stall cycles = N exactly.
  - After returning to IDLE, hazards are re-evaluated normally; a back-to-back restall is legal.
- Flush:
  - IFID_Flush = BRANCH_IN_ID && BranchTaken && !stall_now. stall_now means an IDLE hazard with N>0, or the STALL state.
  - During a stall, BranchTaken is ignored: the branch operands are invalid.
  - Flush never coincides with a stall cycle.
- StallCount:
  - Increments on every edge where stall_now=1.
  - Saturates at 2^CNT_W−1; no wrap.
  - CountClear has priority over increment and loads 0.
- Reset low, asynchronous, at any time including mid-STALL:
  - State=IDLE, cnt=0, StallCount=0.
  - Outputs forced to PC_WriteEnable=1, IFID_WriteEnable=1, IDEX_Bubble=0, IFID_Flush=0, Stalling=0, irrespective of inputs.
  - Normal operation resumes on the first edge after Reset rises.
- All outputs are glitch-tolerant combinational decodes of state and inputs, except StallCount, which is registered.

Test Plan:
- LOAD_STALL=1: EX lw $8, ID add $9,$8,$3 (UsesRs) → exactly 1 cycle with enables=0 and bubble=1, Stalling stays 0, StallCount=1.
- LOAD_STALL=3: same pair → 3 consecutive stall cycles, Stalling=1 on cycles 2–3, then enables=1; a mid-stall change of EX_WriteReg has no effect; StallCount=3.
- EX add $5 with ID beq $5,$0, BRANCH_STALL=1 → 1 stall. EX lw $5 with ID beq $5,$0 → LOAD_STALL+1=2 stalls. EX_WriteReg=0 with ID_Rs=0 → no stall.
- BranchTaken=1 with no hazard → IFID_Flush=1 for 1 cycle, PC_WriteEnable=1. BranchTaken=1 during a stall → IFID_Flush=0.
- Drive Reset low on the 2nd cycle of a 3-cycle stall → enables=1 and StallCount=0 immediately, without waiting for a clock edge; after release, no residual stall.
- CNT_W=4: force 20 stall cycles → StallCount holds 15. CountClear together with a stall → 0.
